// File: rtl/control_mac.sv
// control_mac: FSM that sequences TAPS multiply-accumulate steps through an external adder.
// Define CONTROL_MAC_SATURACION_EN to clamp signed overflow and report it on sat_flag.
module control_mac #(
    parameter int N      = 24,
    parameter int TAPS   = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2*N-1:0]    Multiplica,
    input  logic [2*N-1:0]    Suma_G,
    output logic [2*N-1:0]    Sum_ext,
    output logic [ADDR_W-1:0] addr,
    output logic              mult_en,
    output logic              busy,
    output logic              done,
    output logic [2*N-1:0]    resultado,
    output logic              sat_flag
);
    localparam int W = 2 * N;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPS - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, ACUM, FIN} state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      acc_q, acc_d, res_q, res_d, sum_sel;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              sat_q, sat_d, ovf;

`ifdef CONTROL_MAC_SATURACION_EN
    // Overflow only when both operands share a sign the result does not.
    assign ovf     = (Multiplica[W-1] == Sum_ext[W-1]) && (Suma_G[W-1] != Multiplica[W-1]);
    assign sum_sel = !ovf ? Suma_G : Multiplica[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
    logic unused_mult;
    assign unused_mult = ^Multiplica;
    assign ovf         = 1'b0;
    assign sum_sel     = Suma_G;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        res_d   = res_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE:  state_d = start ? CLEAR : IDLE;
            CLEAR: begin
                acc_d   = '0;
                idx_d   = '0;
                sat_d   = 1'b0;
                state_d = ACUM;
            end
            ACUM: begin
                acc_d   = sum_sel;
                idx_d   = idx_q + 1'b1;
                sat_d   = sat_q | ovf;
                res_d   = (idx_q == LAST) ? sum_sel : res_q;
                state_d = (idx_q == LAST) ? FIN : ACUM;
            end
            FIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            res_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            sat_q   <= sat_d;
        end
    end

    assign Sum_ext   = acc_q;
    assign addr      = (state_q == ACUM) ? idx_q : '0;
    assign mult_en   = (state_q == ACUM);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign resultado = res_q;
    assign sat_flag  = sat_q;
endmodule

// File: tb/tb_control_mac.sv
// tb_control_mac: randomized self-checking bench for control_mac (N=24, TAPS=4, ADDR_W=2).
module tb_control_mac;
    localparam longint SMAX = 64'sh0000_7FFF_FFFF_FFFF;
    localparam longint SMIN = -SMAX - 1;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [47:0] Multiplica, Suma_G, Sum_ext, resultado;
    logic [1:0]  addr;
    logic        mult_en, busy, done, sat_flag;
    logic [47:0] prod [4];

    int          errors = 0, checks = 0;
    int          done_k, done_cnt, busy_cnt, trace_err;
    logic [47:0] res_at_done;
    logic        sat_at_done;

    control_mac #(.N(24), .TAPS(4), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset), .start(start), .Multiplica(Multiplica), .Suma_G(Suma_G),
        .Sum_ext(Sum_ext), .addr(addr), .mult_en(mult_en), .busy(busy), .done(done),
        .resultado(resultado), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;
    assign Multiplica = prod[addr];
    assign Suma_G     = Multiplica + Sum_ext;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [47:0] model_sum(output logic s);
        longint      acc = 0;
        logic [47:0] t;
        s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            acc += longint'($signed(prod[i]));
`ifdef CONTROL_MAC_SATURACION_EN
            if (acc > SMAX) begin acc = SMAX; s = 1'b1; end
            else if (acc < SMIN) begin acc = SMIN; s = 1'b1; end
`else
            t = acc[47:0];
            acc = longint'($signed(t));
`endif
        end
        t = acc[47:0];
        return t;
    endfunction

    task automatic randomize_prod();
        logic [63:0] r;
        for (int i = 0; i < 4; i++) begin
            r = {$urandom(), $urandom()};
            prod[i] = r[47:0];
        end
    endtask

    task automatic do_run();
        done_k = -1; done_cnt = 0; busy_cnt = 0; trace_err = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_k < 0) begin done_k = k; res_at_done = resultado; sat_at_done = sat_flag; end
            end
            if (mult_en !== (k >= 1 && k <= 4)) trace_err++;
            if (addr !== ((k >= 1 && k <= 4) ? 2'(k - 1) : 2'd0)) trace_err++;
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({busy, done, mult_en, addr, sat_flag} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 000000", {busy, done, mult_en, addr, sat_flag});
        end
        checks++;
        if (resultado !== 48'h0 || Sum_ext !== 48'h0) begin
            errors++; $display("FAIL reset_data: resultado=%h Sum_ext=%h want 0", resultado, Sum_ext);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_const_one();
        for (int i = 0; i < 4; i++) prod[i] = 48'd1;
        do_run();
        checks++;
        if (done_k !== 5) begin errors++; $display("FAIL one_latency: got %0d want 5", done_k); end
        checks++;
        if (trace_err !== 0) begin errors++; $display("FAIL one_addr_trace: got %0d errs want 0", trace_err); end
        checks++;
        if (res_at_done !== 48'd4) begin errors++; $display("FAIL one_result: got %h want 4", res_at_done); end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < 4; i++) prod[i] = 48'(i + 1);
        do_run();
        checks++;
        if (res_at_done !== 48'd10) begin errors++; $display("FAIL ramp_result: got %h want a", res_at_done); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL ramp_done_pulses: got %0d want 1", done_cnt); end
        checks++;
        if (busy_cnt !== 6) begin errors++; $display("FAIL ramp_busy_cycles: got %0d want 6", busy_cnt); end
    endtask

    task automatic test_random();
        logic [47:0] exp_r;
        logic        exp_s;
        for (int n = 0; n < 8; n++) begin
            randomize_prod();
            exp_r = model_sum(exp_s);
            do_run();
            checks++;
            if (done_k !== 5 || res_at_done !== exp_r) begin
                errors++; $display("FAIL rand_result[%0d]: got %h at k=%0d want %h at k=5", n, res_at_done, done_k, exp_r);
            end
            checks++;
            if (sat_at_done !== exp_s) begin errors++; $display("FAIL rand_sat[%0d]: got %b want %b", n, sat_at_done, exp_s); end
            checks++;
            if (resultado !== exp_r) begin errors++; $display("FAIL rand_hold[%0d]: got %h want %h", n, resultado, exp_r); end
        end
    endtask

    task automatic test_back_to_back();
        int          dk [$];
        logic [47:0] exp_r;
        logic        exp_s;
        bit          res_ok = 1'b1;
        randomize_prod();
        exp_r = model_sum(exp_s);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin dk.push_back(k); if (resultado !== exp_r) res_ok = 1'b0; end
        end
        start = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (dk.size() !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", dk.size()); end
        checks++;
        if (dk.size() < 2 || dk[1] - dk[0] !== 7) begin
            errors++; $display("FAIL b2b_gap: got %0d want 7", dk.size() < 2 ? -1 : dk[1] - dk[0]);
        end
        checks++;
        if (!res_ok) begin errors++; $display("FAIL b2b_result: got mismatch want %h", exp_r); end
    endtask

    task automatic test_reset_mid_run();
        bit found = 1'b0;
        int dn = 0;
        for (int i = 0; i < 4; i++) prod[i] = 48'(i + 5);
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (mult_en && addr == 2'd2) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL mid_wait_addr2: got timeout want addr=2"); end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, mult_en, addr, sat_flag} !== 6'b0 || resultado !== 48'h0 || Sum_ext !== 48'h0) begin
            errors++; $display("FAIL mid_reset_outputs: got ctrl=%b res=%h sum=%h want all 0",
                               {busy, done, mult_en, addr, sat_flag}, resultado, Sum_ext);
        end
        for (int i = 0; i < 3; i++) begin @(negedge clk); if (done) dn++; end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); if (done || busy) dn++; end
        checks++;
        if (dn !== 0) begin errors++; $display("FAIL mid_no_done: got %0d activity cycles want 0", dn); end
        do_run();
        checks++;
        if (done_k !== 5 || res_at_done !== 48'd26) begin
            errors++; $display("FAIL mid_fresh_run: got %h at k=%0d want 1a at k=5", res_at_done, done_k);
        end
    endtask

    task automatic test_saturation();
`ifdef CONTROL_MAC_SATURACION_EN
        logic [47:0] exp_r = 48'h7FFF_FFFF_FFFF;
        logic        exp_s = 1'b1;
`else
        logic [47:0] exp_r = 48'hFFFF_FFFF_FFFC;
        logic        exp_s = 1'b0;
`endif
        for (int i = 0; i < 4; i++) prod[i] = 48'h3FFF_FFFF_FFFF;
        do_run();
        checks++;
        if (res_at_done !== exp_r) begin errors++; $display("FAIL sat_pos_result: got %h want %h", res_at_done, exp_r); end
        checks++;
        if (sat_at_done !== exp_s) begin errors++; $display("FAIL sat_pos_flag: got %b want %b", sat_at_done, exp_s); end
        for (int i = 0; i < 4; i++) prod[i] = 48'hFFFF_FFFF_FFFF;
        do_run();
        checks++;
        if (res_at_done !== 48'hFFFF_FFFF_FFFC) begin
            errors++; $display("FAIL sat_neg_result: got %h want fffffffffffc", res_at_done);
        end
        checks++;
        if (sat_at_done !== 1'b0) begin errors++; $display("FAIL sat_neg_flag: got %b want 0", sat_at_done); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) prod[i] = 48'h0;
        test_reset();
        test_const_one();
        test_ramp();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/control_mac.md
CONTROL_MAC -- requirements
Module: control_mac

Interface
REQ-001 The block SHALL have parameter N, default 24, setting operand width; all datapath ports are 2*N bits wide.
REQ-002 The block SHALL have parameter TAPS, default 8, setting the number of products accumulated per run; legal range 2..2^ADDR_W.
REQ-003 The block SHALL have parameter ADDR_W, default 3, setting the tap-index width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request a new accumulation run; sampled only in IDLE.
REQ-007 Multiplica  input  2N  signed product for the current tap, valid combinationally for the presented addr.
REQ-008 Suma_G  input  2N  sum returned by the external adder (Multiplica + Sum_ext).
REQ-009 Sum_ext  output  2N  accumulator value fed to the adder's second operand.
REQ-010 addr  output  ADDR_W  tap index for coefficient/sample fetch.
REQ-011 mult_en  output  1  high while a product is being accumulated.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse marking resultado valid.
REQ-014 resultado  output  2N  final accumulated value, held until the next run completes.
REQ-015 sat_flag  output  1  sticky saturation indicator for the last run.

Function
REQ-016 The FSM SHALL have states IDLE, CLEAR, ACUM and FIN, encoded in a registered state variable.
REQ-017 IDLE: start=1 at an edge SHALL move to CLEAR; start=0 SHALL hold IDLE.
REQ-018 CLEAR: the next edge SHALL load accumulator=0, index=0 and sat_flag=0, and move to ACUM.
REQ-019 ACUM: each edge SHALL load accumulator<=Suma_G and increment index; the edge at index=TAPS-1 SHALL also load resultado<=Suma_G and move to FIN.
REQ-020 FIN: done SHALL be 1 for exactly this one cycle; the next edge SHALL return to IDLE.
REQ-021 Sum_ext SHALL equal the accumulator register at all times.
REQ-022 addr SHALL equal the index in ACUM and 0 in all other states; mult_en SHALL be 1 only in ACUM.
REQ-023 Latency: done SHALL be high in the cycle following the (TAPS+1)-th edge after the edge that sampled start; runs are back-to-back no faster than TAPS+3 cycles.
REQ-024 start in CLEAR, ACUM or FIN SHALL be ignored and not queued.
REQ-025 Without saturation, accumulation SHALL wrap modulo 2^(2N).
REQ-026 resultado SHALL keep its value in IDLE, CLEAR and ACUM until overwritten on the final ACUM edge.

Reset
REQ-027 reset=1 SHALL immediately force state=IDLE, accumulator=0, index=0, resultado=0, sat_flag=0, done=0, busy=0, mult_en=0, addr=0, irrespective of clk.
REQ-028 reset asserted mid-run SHALL abort the run without a done pulse; the first start after release SHALL begin a full fresh run.

Configuration
REQ-029 Macro CONTROL_MAC_SATURACION_EN, when defined, SHALL make ACUM detect signed overflow (Multiplica and Sum_ext same sign, Suma_G sign different) and load the 2N-bit signed max (positive overflow) or min (negative overflow) instead of Suma_G, setting sat_flag=1 until the next CLEAR.
REQ-030 Without CONTROL_MAC_SATURACION_EN the accumulator SHALL always load Suma_G and sat_flag SHALL be tied to 0.

Verification (N=24, TAPS=4, ADDR_W=2, bench models adder as Multiplica+Sum_ext)
REQ-031 Multiplica=1 constant, one start pulse -> addr 0,1,2,3 with mult_en=1, done at cycle 5 after start edge, resultado=4.
REQ-032 Multiplica=addr+1 per tap (1,2,3,4) -> resultado=10, done single-cycle, busy high 6 cycles.
REQ-033 start held high across whole run -> one run per IDLE visit, second done exactly 7 cycles after first.
REQ-034 reset pulsed during ACUM at addr=2 -> all outputs 0 immediately, no done; next start yields correct resultado.
REQ-035 With macro, Multiplica=0x3FFF_FFFF_FFFF each tap -> resultado=0x7FFF_FFFF_FFFF, sat_flag=1; without macro resultado=0xFFFF_FFFF_FFFC, sat_flag=0.
REQ-036 Multiplica=-1 (0xFFFF_FFFF_FFFF) each tap -> resultado=0xFFFF_FFFF_FFFC (-4), sat_flag=0 in both builds.
